// File: rtl/svga_timing_pkg.sv
// Default SVGA 800x600@72Hz timing constants and counter widths shared by the
// sync generator and its per-axis counters.
package svga_timing_pkg;
   localparam int DEF_H_VISIBLE = 800;
   localparam int DEF_H_FRONT   = 56;
   localparam int DEF_H_SYNC    = 120;
   localparam int DEF_H_BACK    = 64;
   localparam int DEF_V_VISIBLE = 600;
   localparam int DEF_V_FRONT   = 37;
   localparam int DEF_V_SYNC    = 6;
   localparam int DEF_V_BACK    = 23;

   localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
   localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

   localparam int H_W = 11;
   localparam int V_W = 10;
endpackage

// File: rtl/svga_axis_counter.sv
// Wrapping position counter for one video axis, with sync and visible decode
// taken from the next count so the decode lines up with the registered count.
module svga_axis_counter #(
   parameter int             W          = 11,
   parameter logic [W-1:0]   TOTAL      = '1,
   parameter logic [W-1:0]   VISIBLE    = '0,
   parameter logic [W-1:0]   SYNC_START = '0,
   parameter logic [W-1:0]   SYNC_END   = '0,
   parameter bit             SYNC_POL   = 1'b1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         wrap,
   output logic         visible_next,
   output logic         sync
);

   logic [W-1:0] count_q = '0;
   logic [W-1:0] count_d;
   logic         sync_q  = ~SYNC_POL;
   logic         sync_d;
   logic         at_last;

   always_comb begin
      at_last = (count_q == TOTAL - 1'b1);
      wrap    = en && at_last;
      count_d = count_q;
      if (en) begin
         count_d = at_last ? '0 : count_q + 1'b1;
      end
      visible_next = (count_d < VISIBLE);
      sync_d       = ((count_d >= SYNC_START) && (count_d < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
   end

   // Reset lands on position 0, which is never inside the sync window.
   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
         sync_q  <= ~SYNC_POL;
      end else begin
         count_q <= count_d;
         sync_q  <= sync_d;
      end
   end

   assign count = count_q;
   assign sync  = sync_q;

endmodule

// File: rtl/svga_sync.sv
// SVGA raster timing generator: horizontal and vertical position counters with
// registered hsync, vsync and video_enable that all describe the same pixel.
module svga_sync
   import svga_timing_pkg::*;
#(
   parameter int H_VISIBLE = DEF_H_VISIBLE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_VISIBLE = DEF_V_VISIBLE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1
) (
   input  logic           clock,
   input  logic           reset,
   output logic           hsync,
   output logic           vsync,
   output logic           video_enable,
   output logic [H_W-1:0] pixel_x,
   output logic [V_W-1:0] pixel_y
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   logic h_wrap;
   logic v_wrap_unused;
   logic h_visible_next;
   logic v_visible_next;
   logic video_enable_q = 1'b1;
   logic video_enable_d;

   svga_axis_counter #(
      .W          (H_W),
      .TOTAL      (H_W'(H_TOTAL)),
      .VISIBLE    (H_W'(H_VISIBLE)),
      .SYNC_START (H_W'(H_VISIBLE + H_FRONT)),
      .SYNC_END   (H_W'(H_VISIBLE + H_FRONT + H_SYNC)),
      .SYNC_POL   (HSYNC_POL)
   ) u_h_axis (
      .clock        (clock),
      .reset        (reset),
      .en           (1'b1),
      .count        (pixel_x),
      .wrap         (h_wrap),
      .visible_next (h_visible_next),
      .sync         (hsync)
   );

   // The vertical axis advances only on the clock where the line wraps.
   svga_axis_counter #(
      .W          (V_W),
      .TOTAL      (V_W'(V_TOTAL)),
      .VISIBLE    (V_W'(V_VISIBLE)),
      .SYNC_START (V_W'(V_VISIBLE + V_FRONT)),
      .SYNC_END   (V_W'(V_VISIBLE + V_FRONT + V_SYNC)),
      .SYNC_POL   (VSYNC_POL)
   ) u_v_axis (
      .clock        (clock),
      .reset        (reset),
      .en           (h_wrap),
      .count        (pixel_y),
      .wrap         (v_wrap_unused),
      .visible_next (v_visible_next),
      .sync         (vsync)
   );

   always_comb begin
      video_enable_d = h_visible_next & v_visible_next;
   end

   // Registered here rather than ANDing two registered flags, which could glitch.
   always_ff @(posedge clock) begin
      if (reset) begin
         video_enable_q <= 1'b1;
      end else begin
         video_enable_q <= video_enable_d;
      end
   end

   assign video_enable = video_enable_q;

endmodule

// File: tb/tb_svga_sync.sv
// Directed bench for svga_sync: a default-timing instance for line-level checks
// and a tiny-timing instance for whole-frame checks within a short run.
module tb_svga_sync;
   localparam int A_HT = 1040;
   localparam int A_VT = 666;
   localparam int B_HT = 15;
   localparam int B_VT = 12;

   logic        clock = 1'b0;
   logic        rst_a = 1'b1;
   logic        rst_b = 1'b1;
   logic        hs_a, vs_a, ve_a, hs_b, vs_b, ve_b;
   logic [10:0] px_a, px_b;
   logic [9:0]  py_a, py_b;

   int total = 0;
   int bad   = 0;
   int ax = 0, ay = 0, bx = 0, by = 0;

   always #5 clock = ~clock;

   svga_sync dut_a (
      .clock        (clock),
      .reset        (rst_a),
      .hsync        (hs_a),
      .vsync        (vs_a),
      .video_enable (ve_a),
      .pixel_x      (px_a),
      .pixel_y      (py_a)
   );

   svga_sync #(
      .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (2),
      .V_VISIBLE (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2),
      .HSYNC_POL (1'b1), .VSYNC_POL (1'b1)
   ) dut_b (
      .clock        (clock),
      .reset        (rst_b),
      .hsync        (hs_b),
      .vsync        (vs_b),
      .video_enable (ve_b),
      .pixel_x      (px_b),
      .pixel_y      (py_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_models();
      chk("a_x",  32'(px_a), 32'(ax));
      chk("a_y",  32'(py_a), 32'(ay));
      chk("a_ve", 32'(ve_a), 32'(ax < 800 && ay < 600));
      chk("a_hs", 32'(hs_a), 32'(ax >= 856 && ax < 976));
      chk("a_vs", 32'(vs_a), 32'(ay >= 637 && ay < 643));
      chk("b_x",  32'(px_b), 32'(bx));
      chk("b_y",  32'(py_b), 32'(by));
      chk("b_ve", 32'(ve_b), 32'(bx < 8 && by < 6));
      chk("b_hs", 32'(hs_b), 32'(bx >= 10 && bx < 13));
      chk("b_vs", 32'(vs_b), 32'(by >= 8 && by < 10));
   endtask

   // One clock; reference positions advance, then every output is compared.
   task automatic tick();
      bit ra, rb;
      ra = rst_a;
      rb = rst_b;
      @(posedge clock);
      #1;
      if (ra) begin
         ax = 0; ay = 0;
      end else if (ax == A_HT - 1) begin
         ax = 0; ay = (ay == A_VT - 1) ? 0 : ay + 1;
      end else begin
         ax++;
      end
      if (rb) begin
         bx = 0; by = 0;
      end else if (bx == B_HT - 1) begin
         bx = 0; by = (by == B_VT - 1) ? 0 : by + 1;
      end else begin
         bx++;
      end
      check_models();
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int rise, fall, width, vcnt, vmin, vmax, flen;
      logic prev;

      #1;
      chk("pwrup_x",  32'(px_a), 32'd0);
      chk("pwrup_ve", 32'(ve_a), 32'd1);
      chk("pwrup_hs", 32'(hs_a), 32'd0);

      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_x",  32'(px_a), 32'd0);
         chk("rst_y",  32'(py_a), 32'd0);
         chk("rst_ve", 32'(ve_a), 32'd1);
         chk("rst_hs", 32'(hs_a), 32'd0);
         chk("rst_vs", 32'(vs_a), 32'd0);
      end
      rst_a = 1'b0;
      rst_b = 1'b0;
      tick();
      chk("rel_x", 32'(px_a), 32'd1);
      chk("rel_y", 32'(py_a), 32'd0);
      $display("reset release: x=%0d y=%0d", px_a, py_a);

      run(799);
      chk("x800_x",  32'(px_a), 32'd800);
      chk("x800_ve", 32'(ve_a), 32'd0);
      chk("x800_hs", 32'(hs_a), 32'd0);
      $display("blanking start: x=%0d ve=%0d hs=%0d", px_a, ve_a, hs_a);

      rise = -1; fall = -1; width = 0; prev = hs_a;
      for (int i = 0; i < 176; i++) begin
         tick();
         if (hs_a === 1'b1) begin
            width++;
            if (rise < 0) rise = int'(px_a);
         end
         if (prev === 1'b1 && hs_a === 1'b0 && fall < 0) fall = int'(px_a);
         prev = hs_a;
      end
      chk("hs_rise",  32'(rise),  32'd856);
      chk("hs_fall",  32'(fall),  32'd976);
      chk("hs_width", 32'(width), 32'd120);
      $display("hsync pulse: rise=%0d fall=%0d width=%0d", rise, fall, width);

      run(63);
      chk("eol_x", 32'(px_a), 32'd1039);
      chk("eol_y", 32'(py_a), 32'd0);
      tick();
      chk("nl_x",  32'(px_a), 32'd0);
      chk("nl_y",  32'(py_a), 32'd1);
      chk("nl_ve", 32'(ve_a), 32'd1);
      $display("line wrap: x=%0d y=%0d ve=%0d", px_a, py_a, ve_a);

      run(500);
      chk("mid_x", 32'(px_a), 32'd500);
      rst_a = 1'b1;
      tick();
      chk("midrst_x",  32'(px_a), 32'd0);
      chk("midrst_y",  32'(py_a), 32'd0);
      chk("midrst_ve", 32'(ve_a), 32'd1);
      chk("midrst_hs", 32'(hs_a), 32'd0);
      rst_a = 1'b0;
      tick();
      chk("midrel_x", 32'(px_a), 32'd1);
      $display("mid-line reset: x=%0d y=%0d", px_a, py_a);

      run(899);
      chk("insync_hs", 32'(hs_a), 32'd1);
      rst_a = 1'b1;
      tick();
      chk("syncrst_hs", 32'(hs_a), 32'd0);
      chk("syncrst_x",  32'(px_a), 32'd0);
      rst_a = 1'b0;
      tick();
      $display("reset during hsync: hs=%0d x=%0d", hs_a, px_a);

      rst_b = 1'b1;
      tick();
      chk("b_rst_x", 32'(px_b), 32'd0);
      rst_b = 1'b0;
      tick();
      chk("b_rel_x", 32'(px_b), 32'd1);
      run(178);
      chk("b_eof_x",  32'(px_b), 32'd14);
      chk("b_eof_y",  32'(py_b), 32'd11);
      chk("b_eof_vs", 32'(vs_b), 32'd0);
      tick();
      chk("b_sof_x",  32'(px_b), 32'd0);
      chk("b_sof_y",  32'(py_b), 32'd0);
      chk("b_sof_ve", 32'(ve_b), 32'd1);
      $display("frame wrap: x=%0d y=%0d", px_b, py_b);

      vcnt = 0; vmin = 999; vmax = -1; flen = -1;
      for (int i = 1; i <= 180; i++) begin
         tick();
         if (vs_b === 1'b1) begin
            vcnt++;
            if (int'(py_b) < vmin) vmin = int'(py_b);
            if (int'(py_b) > vmax) vmax = int'(py_b);
         end
         if (px_b == 11'd0 && py_b == 10'd0 && flen < 0) flen = i;
      end
      chk("b_vs_cycles", 32'(vcnt), 32'd30);
      chk("b_vs_first",  32'(vmin), 32'd8);
      chk("b_vs_last",   32'(vmax), 32'd9);
      chk("b_frame_len", 32'(flen), 32'd180);
      $display("frame: vsync cycles=%0d lines=%0d..%0d length=%0d", vcnt, vmin, vmax, flen);

      run(131);
      chk("b_mid_x",  32'(px_b), 32'd11);
      chk("b_mid_y",  32'(py_b), 32'd8);
      chk("b_mid_hs", 32'(hs_b), 32'd1);
      chk("b_mid_vs", 32'(vs_b), 32'd1);
      rst_b = 1'b1;
      tick();
      chk("b_midrst_hs", 32'(hs_b), 32'd0);
      chk("b_midrst_vs", 32'(vs_b), 32'd0);
      chk("b_midrst_ve", 32'(ve_b), 32'd1);
      rst_b = 1'b0;
      tick();
      chk("b_midrel_x", 32'(px_b), 32'd1);
      chk("b_midrel_y", 32'(py_b), 32'd0);
      $display("mid-frame reset: x=%0d y=%0d hs=%0d vs=%0d", px_b, py_b, hs_b, vs_b);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/svga_sync.md
SVGA_SYNC -- requirements
Module: svga_sync

Interface
REQ-001 Parameters SHALL be: H_VISIBLE 800, H_FRONT 56, H_SYNC 120, H_BACK 64, V_VISIBLE 600, V_FRONT 37, V_SYNC 6, V_BACK 23, HSYNC_POL 1, VSYNC_POL 1 (1 = active-high sync).
REQ-002 Port clock SHALL be an input, 1 bit: pixel clock, 50 MHz, the single clock of the block; all logic on its rising edge.
REQ-003 Port reset SHALL be an input, 1 bit: reset is synchronous and active-high.
REQ-004 Port hsync SHALL be an output, 1 bit: horizontal sync, polarity per HSYNC_POL.
REQ-005 Port vsync SHALL be an output, 1 bit: vertical sync, polarity per VSYNC_POL.
REQ-006 Port video_enable SHALL be an output, 1 bit: high only while the current pixel is in the visible 800x600 area.
REQ-007 Port pixel_x SHALL be an output, 11 bits: current horizontal position, 0..H_TOTAL-1.
REQ-008 Port pixel_y SHALL be an output, 10 bits: current vertical position, 0..V_TOTAL-1.

Function
REQ-009 The block SHALL derive H_TOTAL = sum of the four H parameters (1040) and V_TOTAL = sum of the four V parameters (666); defaults give SVGA 800x600 at 72 Hz.
REQ-010 pixel_x SHALL increment by 1 on every clock edge and wrap from H_TOTAL-1 (1039) to 0.
REQ-011 pixel_y SHALL increment by 1 only on the edge where pixel_x wraps, and wrap from V_TOTAL-1 (665) to 0 on the edge where both counters are at their maximum.
REQ-012 video_enable SHALL be 1 exactly when pixel_x < H_VISIBLE and pixel_y < V_VISIBLE.
REQ-013 hsync SHALL be active exactly when H_VISIBLE+H_FRONT <= pixel_x < H_VISIBLE+H_FRONT+H_SYNC (856..975 by default), and inactive otherwise.
REQ-014 vsync SHALL be active exactly when V_VISIBLE+V_FRONT <= pixel_y < V_VISIBLE+V_FRONT+V_SYNC (637..642 by default), for whole lines, independent of pixel_x.
REQ-015 hsync, vsync and video_enable SHALL be registered outputs computed from the next counter values, so all five outputs describe the same pixel in the same cycle, with zero skew and no combinational glitches.
REQ-016 Frame period SHALL be H_TOTAL*V_TOTAL = 692640 clocks, and line period H_TOTAL = 1040 clocks.
REQ-017 Counters SHALL never take values outside their ranges; out-of-range values are impossible by construction, with no saturation logic.

Reset
REQ-018 While reset is 1 at a clock edge, pixel_x SHALL be 0, pixel_y SHALL be 0, video_enable SHALL be 1, and hsync/vsync SHALL be inactive (the decode of position (0,0)).
REQ-019 On the first edge after reset deasserts, pixel_x SHALL be 1 and counting SHALL continue normally.
REQ-020 Reset asserted mid-line or mid-frame SHALL restart at (0,0) on the same edge, with no partial sync pulse extended past that edge.
REQ-021 Before the first reset, the registers SHALL power up (initial values) to the reset state.

Structure
REQ-022 A shared package svga_timing_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL, and the counter widths (11 horizontal, 10 vertical).
REQ-023 One sub-module, svga_axis_counter, SHALL implement a parameterized wrapping counter with enable, wrap-out, and registered active/sync/visible decode; it SHALL be instantiated once per axis, with the vertical enable driven by the horizontal wrap.
REQ-024 No other hierarchy, memories, or additional clock domains SHALL exist.

Verification
REQ-025 Reset for 3 clocks, then release -> pixel_x=0, pixel_y=0, video_enable=1, hsync=0, vsync=0 during reset; pixel_x=1 one clock after release.
REQ-026 Run 800 clocks from (0,0) -> pixel_x=800, video_enable=0, hsync=0; hsync=1 at pixel_x=856, returns to 0 at pixel_x=976 (120 clocks wide).
REQ-027 Run to pixel_x=1039, pixel_y=0, then one clock -> pixel_x=0, pixel_y=1, video_enable=1.
REQ-028 Full frame -> vsync=1 for lines 637..642 only (6*1040=6240 clocks); at (1039,665) the next clock gives (0,0); frame length measures 692640 clocks.
REQ-029 Assert reset at (500,300) -> next edge gives (0,0) with the REQ-018 values; syncs inactive; the sequence resumes from REQ-025.
REQ-030 Continuous check over two frames -> video_enable equals (pixel_x<800 && pixel_y<600) on every cycle, and pixel_x never exceeds 1039, pixel_y never exceeds 665.
